// File: rtl/periph_mailbox_target.sv
// Peripheral-port responder: end-of-test mailbox, doorbell, 64-bit cycle counter, watchdog, scratch.
// Define PERIPH_MAILBOX_TARGET_STALL_EN to add pseudo-random grant stalls from a 16-bit LFSR.
module periph_mailbox_target #(
    parameter int          ID             = 10,
    parameter int          N_SCRATCH      = 8,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF,
    parameter logic [63:0] CYCLE_RESET    = 64'd0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          enable_i,
    input  logic          periph_req,
    input  logic [31:0]   periph_add,
    input  logic          periph_wen,
    input  logic [3:0]    periph_be,
    input  logic [31:0]   periph_data,
    input  logic [ID-1:0] periph_id,
    output logic          periph_gnt,
    output logic          periph_r_valid,
    output logic [31:0]   periph_r_data,
    output logic [ID-1:0] periph_r_id,
    output logic          evt_o,
    output logic          done_o,
    output logic [31:0]   errors_o,
    output logic          timeout_o
);

    localparam logic [5:0] OFF_MAILBOX  = 6'd0;
    localparam logic [5:0] OFF_STATUS   = 6'd1;
    localparam logic [5:0] OFF_DOORBELL = 6'd2;
    localparam logic [5:0] OFF_CYCLE_LO = 6'd3;
    localparam logic [5:0] OFF_CYCLE_HI = 6'd4;
    localparam logic [5:0] OFF_SCRATCH  = 6'd5;

    logic [5:0]  offset;
    logic [5:0]  scratchIdx;
    logic        isScratch;
    logic        grant;
    logic        isWrite;
    logic        mbWrite;
    logic        wdActive;
    logic [31:0] readData;
    logic        unusedAddrBits;

    logic          rValid_q,  rValid_d;
    logic [ID-1:0] rId_q,     rId_d;
    logic [31:0]   rData_q,   rData_d;
    logic          evt_q,     evt_d;
    logic          done_q,    done_d;
    logic          timeout_q, timeout_d;
    logic [31:0]   errors_q,  errors_d;
    logic [15:0]   dbCount_q, dbCount_d;
    logic [63:0]   cycle_q,   cycle_d;
    logic [31:0]   hiSnap_q,  hiSnap_d;
    logic [31:0]   wdCnt_q,   wdCnt_d;
    logic [31:0]   scratch_q [N_SCRATCH];
    logic [31:0]   scratch_d [N_SCRATCH];

`ifdef PERIPH_MAILBOX_TARGET_STALL_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11; low two bits == 0 stalls the grant.
    assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign periph_gnt = periph_req & (lfsr_q[1:0] != 2'b00);

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign periph_gnt = periph_req;
`endif

    assign offset         = periph_add[7:2];
    assign unusedAddrBits = ^{periph_add[31:8], periph_add[1:0]};
    assign grant          = periph_req & periph_gnt & ~rst_i;
    assign isWrite        = ~periph_wen;
    assign mbWrite        = grant & isWrite & (offset == OFF_MAILBOX);
    assign scratchIdx     = offset - OFF_SCRATCH;
    assign isScratch      = ({1'b0, offset} >= 7'd5) && ({1'b0, offset} < 7'(5 + N_SCRATCH));
    assign wdActive       = (TIMEOUT_CYCLES != 0) && enable_i && !done_q && !timeout_q;

    function automatic logic [31:0] beMerge(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  be);
        logic [31:0] res;
        res = oldVal;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = newVal[8*b +: 8];
        end
        return res;
    endfunction

    always_comb begin
        readData = ERR_RDATA;
        case (offset)
            OFF_MAILBOX:  readData = errors_q;
            OFF_STATUS:   readData = {29'd0, enable_i, timeout_q, done_q};
            OFF_DOORBELL: readData = {16'd0, dbCount_q};
            OFF_CYCLE_LO: readData = cycle_q[31:0];
            OFF_CYCLE_HI: readData = hiSnap_q;
            default: begin
                for (int i = 0; i < N_SCRATCH; i++) begin
                    if (isScratch && (scratchIdx == 6'(i))) readData = scratch_q[i];
                end
            end
        endcase
    end

    always_comb begin
        rValid_d  = grant;
        rId_d     = grant ? periph_id : '0;
        rData_d   = (grant && !isWrite) ? readData : 32'd0;
        evt_d     = grant & isWrite & (offset == OFF_DOORBELL);
        done_d    = done_q | mbWrite;
        errors_d  = mbWrite ? beMerge(errors_q, periph_data, periph_be) : errors_q;
        dbCount_d = evt_d ? dbCount_q + 16'd1 : dbCount_q;
        cycle_d   = enable_i ? cycle_q + 64'd1 : cycle_q;
        hiSnap_d  = (grant && !isWrite && offset == OFF_CYCLE_LO) ? cycle_q[63:32] : hiSnap_q;
        wdCnt_d   = wdCnt_q;
        timeout_d = timeout_q;
        scratch_d = scratch_q;
        for (int i = 0; i < N_SCRATCH; i++) begin
            if (grant && isWrite && isScratch && (scratchIdx == 6'(i)))
                scratch_d[i] = beMerge(scratch_q[i], periph_data, periph_be);
        end
        // A mailbox write landing on the expiry cycle wins: done is set, timeout is not.
        if (wdActive) begin
            if (wdCnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                if (!mbWrite) timeout_d = 1'b1;
            end else begin
                wdCnt_d = wdCnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rValid_q  <= 1'b0;
            rId_q     <= '0;
            rData_q   <= '0;
            evt_q     <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            errors_q  <= '0;
            dbCount_q <= '0;
            cycle_q   <= CYCLE_RESET;
            hiSnap_q  <= '0;
            wdCnt_q   <= '0;
            for (int i = 0; i < N_SCRATCH; i++) scratch_q[i] <= '0;
        end else begin
            rValid_q  <= rValid_d;
            rId_q     <= rId_d;
            rData_q   <= rData_d;
            evt_q     <= evt_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            errors_q  <= errors_d;
            dbCount_q <= dbCount_d;
            cycle_q   <= cycle_d;
            hiSnap_q  <= hiSnap_d;
            wdCnt_q   <= wdCnt_d;
            scratch_q <= scratch_d;
        end
    end

    assign periph_r_valid = rValid_q;
    assign periph_r_id    = rId_q;
    assign periph_r_data  = rData_q;
    assign evt_o          = evt_q;
    assign done_o         = done_q;
    assign errors_o       = errors_q;
    assign timeout_o      = timeout_q;

endmodule
